// File: rtl/pwm_bank.sv
// pwm_bank: bank of independent double-buffered PWM channels with shared enable, sync and reset
module pwm_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        en,
  input  logic                        sync,
  input  logic [CHANNELS-1:0]         ld,
  input  logic [CHANNELS*WIDTH-1:0]   hi,
  input  logic [CHANNELS*WIDTH-1:0]   lo,
  output logic [CHANNELS-1:0]         pwm_o,
  output logic [CHANNELS-1:0]         per_o
);
  localparam logic [WIDTH:0] ONE = 1;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] r_sh_hi, r_sh_lo, r_ac_hi, r_ac_lo, w_sh_hi_nxt, w_sh_lo_nxt;
    logic [WIDTH:0]   r_cnt, w_per;
    logic             r_pend, r_pwm, r_per, w_bnd;
    // next shadow contents and period-boundary detect (zero-length period ends every cycle)
    always_comb begin
      w_sh_hi_nxt = ld[i] ? hi[i*WIDTH +: WIDTH] : r_sh_hi;
      w_sh_lo_nxt = ld[i] ? lo[i*WIDTH +: WIDTH] : r_sh_lo;
      w_per       = {1'b0, r_ac_hi} + {1'b0, r_ac_lo};
      w_bnd       = (w_per == '0) || (r_cnt == w_per - ONE);
    end
    // counter, double buffer and registered outputs; a load in a boundary cycle waits for the next boundary
    always_ff @(posedge clk) begin
      if (srst) begin
        r_sh_hi <= '0;
        r_sh_lo <= '0;
        r_ac_hi <= '0;
        r_ac_lo <= '0;
        r_cnt   <= '0;
        r_pend  <= 1'b0;
        r_pwm   <= 1'b0;
        r_per   <= 1'b0;
      end else begin
        r_sh_hi <= w_sh_hi_nxt;
        r_sh_lo <= w_sh_lo_nxt;
        r_pwm   <= en && (r_cnt < {1'b0, r_ac_hi});
        r_per   <= en && (r_cnt == '0);
        if (!en) begin
          r_cnt   <= '0;
          r_ac_hi <= w_sh_hi_nxt;
          r_ac_lo <= w_sh_lo_nxt;
          r_pend  <= 1'b0;
        end else if (sync) begin
          r_cnt  <= '0;
          r_pend <= ld[i];
          if (r_pend) begin
            r_ac_hi <= r_sh_hi;
            r_ac_lo <= r_sh_lo;
          end
        end else begin
          r_cnt <= w_bnd ? '0 : r_cnt + ONE;
          if (w_bnd && r_pend) begin
            r_ac_hi <= r_sh_hi;
            r_ac_lo <= r_sh_lo;
            r_pend  <= ld[i];
          end else begin
            r_pend <= r_pend | ld[i];
          end
        end
      end
    end
    assign pwm_o[i] = r_pwm;
    assign per_o[i] = r_per;
  end
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed scenario checks of pwm_bank with hand-derived waveforms
module tb_pwm_bank;
  logic        clk = 1'b0;
  logic        srst, en, sync;
  logic [3:0]  ld;
  logic [31:0] hi, lo;
  logic [3:0]  pwm_o, per_o;
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_bank #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .srst(srst), .en(en), .sync(sync), .ld(ld),
    .hi(hi), .lo(lo), .pwm_o(pwm_o), .per_o(per_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    srst = 1'b1; en = 1'b0; sync = 1'b0; ld = '0; hi = '0; lo = '0;
    tick();
    for (int k = 0; k < 20; k++) begin
      ld = 4'($urandom); hi = $urandom; lo = $urandom;
      en = 1'($urandom); sync = 1'($urandom);
      tick();
      checks += 2;
      if (pwm_o !== 4'b0) begin errs++; $display("FAIL reset_pwm k=%0d got=%b exp=0000", k, pwm_o); end
      if (per_o !== 4'b0) begin errs++; $display("FAIL reset_per k=%0d got=%b exp=0000", k, per_o); end
    end
    srst = 1'b0; en = 1'b0; sync = 1'b0; ld = '0;
    tick();
    checks += 2;
    if (pwm_o !== 4'b0) begin errs++; $display("FAIL reset_rel_pwm got=%b exp=0000", pwm_o); end
    if (per_o !== 4'b0) begin errs++; $display("FAIL reset_rel_per got=%b exp=0000", per_o); end
  endtask

  task automatic test_basic;
    en = 1'b0; ld = 4'b0001; hi = 32'd5; lo = 32'd11;
    tick();
    ld = '0; en = 1'b1;
    for (int k = 0; k < 48; k++) begin
      tick();
      checks += 2;
      if (pwm_o[0] !== ((k % 16) < 5)) begin errs++; $display("FAIL basic_pwm k=%0d got=%b exp=%b", k, pwm_o[0], (k % 16) < 5); end
      if (per_o[0] !== ((k % 16) == 0)) begin errs++; $display("FAIL basic_per k=%0d got=%b exp=%b", k, per_o[0], (k % 16) == 0); end
    end
  endtask

  task automatic test_glitch_free;
    logic ep, eq;
    for (int k = 0; k < 76; k++) begin
      ld = (k == 3) ? 4'b0001 : 4'b0000;
      hi = 32'd8; lo = 32'd12;
      tick();
      ep = (k < 16) ? (k < 5) : (((k - 16) % 20) < 8);
      eq = (k < 16) ? (k == 0) : (((k - 16) % 20) == 0);
      checks += 2;
      if (pwm_o[0] !== ep) begin errs++; $display("FAIL glitch_pwm k=%0d got=%b exp=%b", k, pwm_o[0], ep); end
      if (per_o[0] !== eq) begin errs++; $display("FAIL glitch_per k=%0d got=%b exp=%b", k, per_o[0], eq); end
    end
    ld = '0;
  endtask

  task automatic test_edges;
    logic [3:0] ep, eq;
    en = 1'b0; ld = 4'hF;
    hi = {8'd255, 8'd0, 8'd8, 8'd0};
    lo = {8'd255, 8'd0, 8'd0, 8'd8};
    tick();
    ld = '0; en = 1'b1;
    for (int k = 0; k < 1020; k++) begin
      tick();
      ep = {(k % 510) < 255, 1'b0, 1'b1, 1'b0};
      eq = {(k % 510) == 0, 1'b1, (k % 8) == 0, (k % 8) == 0};
      checks += 2;
      if (pwm_o !== ep) begin errs++; $display("FAIL edges_pwm k=%0d got=%b exp=%b", k, pwm_o, ep); end
      if (per_o !== eq) begin errs++; $display("FAIL edges_per k=%0d got=%b exp=%b", k, per_o, eq); end
    end
  endtask

  task automatic test_sync;
    logic [3:0] ep, eq;
    en = 1'b0; ld = 4'hF; hi = 32'h02020202; lo = 32'h0B0A0908;
    tick();
    ld = '0; en = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    ld = 4'hF; hi = 32'h02020202; lo = 32'h08080808;
    tick();
    ld = '0; sync = 1'b1;
    tick();
    sync = 1'b0;
    checks += 2;
    if (pwm_o !== 4'b1100) begin errs++; $display("FAIL sync_pre_pwm got=%b exp=1100", pwm_o); end
    if (per_o !== 4'b1000) begin errs++; $display("FAIL sync_pre_per got=%b exp=1000", per_o); end
    for (int k = 0; k < 30; k++) begin
      tick();
      ep = ((k % 10) < 2) ? 4'hF : 4'h0;
      eq = ((k % 10) == 0) ? 4'hF : 4'h0;
      checks += 2;
      if (pwm_o !== ep) begin errs++; $display("FAIL sync_pwm k=%0d got=%b exp=%b", k, pwm_o, ep); end
      if (per_o !== eq) begin errs++; $display("FAIL sync_per k=%0d got=%b exp=%b", k, per_o, eq); end
    end
  endtask

  task automatic test_en_drop;
    logic [3:0] ep, eq;
    en = 1'b0; ld = 4'hF; hi = 32'h0A0A0A0A; lo = 32'h06060606;
    tick();
    ld = '0; en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      ld = (k == 5) ? 4'hF : 4'h0;
      if (k == 5) begin hi = 32'h03030303; lo = 32'h04040404; end
      tick();
      eq = (k == 0) ? 4'hF : 4'h0;
      checks += 2;
      if (pwm_o !== 4'hF) begin errs++; $display("FAIL drop_run_pwm k=%0d got=%b exp=1111", k, pwm_o); end
      if (per_o !== eq) begin errs++; $display("FAIL drop_run_per k=%0d got=%b exp=%b", k, per_o, eq); end
    end
    ld = '0; en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks += 2;
      if (pwm_o !== 4'h0) begin errs++; $display("FAIL drop_off_pwm k=%0d got=%b exp=0000", k, pwm_o); end
      if (per_o !== 4'h0) begin errs++; $display("FAIL drop_off_per k=%0d got=%b exp=0000", k, per_o); end
    end
    en = 1'b1;
    for (int k = 0; k < 21; k++) begin
      tick();
      ep = ((k % 7) < 3) ? 4'hF : 4'h0;
      eq = ((k % 7) == 0) ? 4'hF : 4'h0;
      checks += 2;
      if (pwm_o !== ep) begin errs++; $display("FAIL drop_re_pwm k=%0d got=%b exp=%b", k, pwm_o, ep); end
      if (per_o !== eq) begin errs++; $display("FAIL drop_re_per k=%0d got=%b exp=%b", k, per_o, eq); end
    end
  endtask

  task automatic test_srst_mid;
    srst = 1'b1;
    tick();
    checks += 2;
    if (pwm_o !== 4'h0) begin errs++; $display("FAIL srst_mid_pwm got=%b exp=0000", pwm_o); end
    if (per_o !== 4'h0) begin errs++; $display("FAIL srst_mid_per got=%b exp=0000", per_o); end
    srst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks += 2;
      if (pwm_o !== 4'h0) begin errs++; $display("FAIL srst_after_pwm k=%0d got=%b exp=0000", k, pwm_o); end
      if (per_o !== 4'hF) begin errs++; $display("FAIL srst_after_per k=%0d got=%b exp=1111", k, per_o); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch_free();
    test_edges();
    test_sync();
    test_en_drop();
    test_srst_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of each hi/lo duration field.
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent PWM channels.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port srst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  global enable; 0 = all channels stopped and cleared.
REQ-006 SHALL have port sync  input  1  one-cycle strobe restarting all channels at period start.
REQ-007 SHALL have port ld  input  CHANNELS  per-channel load strobe for hi/lo.
REQ-008 SHALL have port hi  input  CHANNELS*WIDTH  high-phase length in cycles; channel i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port lo  input  CHANNELS*WIDTH  low-phase length in cycles; same packing as hi.
REQ-010 SHALL have port pwm_o  output  CHANNELS  registered PWM outputs.
REQ-011 SHALL have port per_o  output  CHANNELS  registered one-cycle period-start pulse per channel.

Function
REQ-012 SHALL hold per channel: shadow hi/lo, active hi/lo, pending flag, period counter cnt of WIDTH+1 bits.
REQ-013 SHALL, on ld[i]=1, capture hi/lo field i into shadow i and set pending i; a later ld before application overwrites shadow (last write wins).
REQ-014 SHALL define period length P = active_hi + active_lo, computed in WIDTH+1 bits (no overflow); P=0 treated as length 1.
REQ-015 SHALL, when enabled, increment cnt each cycle; boundary is cnt == P-1 (or P=0), where cnt wraps to 0.
REQ-016 SHALL, at a boundary with pending set, copy shadow to active and clear pending; a ld in the boundary cycle itself is applied at the next boundary, not this one.
REQ-017 SHALL register pwm_o[i] = en & (cnt_i < active_hi_i), i.e. output lags the counter by one cycle.
REQ-018 SHALL register per_o[i] = 1 in the cycle after cnt_i was 0 while enabled (aligned with first pwm_o sample of the period).
REQ-019 SHALL yield: hi=0 -> pwm_o constant 0; lo=0, hi>0 -> constant 1; hi=lo=0 -> pwm_o 0 and per_o high every enabled cycle.
REQ-020 SHALL, while en=0: cnt held at 0, active loaded from shadow every cycle, pending cleared, pwm_o=0, per_o=0.
REQ-021 SHALL, on en rising at cycle t, treat cycle t as cnt=0 of a fresh period (pwm_o high from t+1 if hi>0).
REQ-022 SHALL, on sync=1 with en=1, force all channels cnt to 0 next cycle and apply any pending shadow immediately, giving phase-aligned rising edges.
REQ-023 SHALL prioritise srst > en=0 > sync > ld/normal counting.
REQ-024 SHALL keep channels fully independent except for shared en, sync, srst.

Reset
REQ-025 SHALL, on srst=1, clear next cycle: cnt, shadow, active, pending of all channels; pwm_o=0, per_o=0.
REQ-026 SHALL, on srst mid-period, abort the period; operation restarts as after power-up reset.

Verification (WIDTH=8, CHANNELS=4)
REQ-027 SHALL cover reset: srst=1 for 20 cycles with random ld/hi/lo/en -> pwm_o=0, per_o=0 throughout and one cycle after release.
REQ-028 SHALL cover basic: ld ch0 hi=5 lo=11 while en=0, then en=1 -> pwm_o[0] 5 high / 11 low, per_o[0] every 16 cycles.
REQ-029 SHALL cover glitch-free update: ch0 running 5/11, ld hi=8 lo=12 at cnt=3 -> current period finishes 5/11, next periods 8/12 (period 20).
REQ-030 SHALL cover edges: hi=0 lo=8 -> constant low, per_o every 8; hi=8 lo=0 -> constant high; hi=lo=0 -> low, per_o every cycle; hi=lo=255 -> period 510.
REQ-031 SHALL cover sync: ch0..3 with 2/8 at staggered phases, sync pulse -> all pwm_o rise together 2 cycles after sync, pending values applied.
REQ-032 SHALL cover en drop mid-period: en=0 at cnt=7 -> pwm_o 0 next cycle; en=1 restarts from cnt 0 with latest shadow values.
